// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle J17 instruction sequencer and stack-pointer owner.
// Define SEQ_RETIRE_COUNT_EN to add the 32-bit retired-instruction counter.
module seq_ctrl #(
  parameter int SP_W        = 8,
  parameter int STACK_DEPTH = 256
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            imem_ready,
  output logic            imem_req,
  output logic            ir_load,
  input  logic [5:0]      opcode,
  input  logic            branch_taken,
  input  logic            dmem_ready,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [SP_W-1:0] dmem_addr,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            reg_we,
  output logic [SP_W-1:0] sp,
  output logic            halted,
  output logic [1:0]      fault
`ifdef SEQ_RETIRE_COUNT_EN
  ,
  output logic [31:0]     retired
`endif
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;
  logic [2:0]  r_state;
  // One spare bit so a completely full stack (STACK_DEPTH == 2^SP_W) is representable.
  logic [SP_W:0] r_sp;
  logic        r_halted;
  logic [1:0]  r_fault;
  logic w_wr_op, w_nop, w_jmp, w_jcc, w_hlt, w_push, w_pop, w_ill, w_full, w_empty;
  logic w_fetch, w_exec, w_mem, w_mem_done, w_stop;
  assign w_wr_op = (opcode <= 6'd14) || (opcode == 6'd24) || (opcode == 6'd29);
  assign w_jmp   = opcode == 6'd15;
  assign w_jcc   = (opcode >= 6'd16) && (opcode <= 6'd23);
  assign w_nop   = opcode == 6'd25;
  assign w_hlt   = opcode == 6'd26;
  assign w_push  = opcode == 6'd27;
  assign w_pop   = opcode == 6'd28;
  assign w_ill   = opcode >= 6'd30;
  assign w_full  = r_sp == (SP_W+1)'(STACK_DEPTH);
  assign w_empty = r_sp == '0;
  assign w_stop  = w_hlt || w_ill || (w_push && w_full) || (w_pop && w_empty);
  assign w_fetch    = !reset && (r_state == S_FETCH);
  assign w_exec     = !reset && (r_state == S_EXEC);
  assign w_mem      = !reset && (r_state == S_MEM);
  assign w_mem_done = w_mem && dmem_ready;
  assign imem_req  = w_fetch;
  assign ir_load   = w_fetch && imem_ready;
  assign dmem_req  = w_mem;
  assign dmem_we   = w_mem && w_push;
  assign dmem_addr = w_push ? r_sp[SP_W-1:0] : r_sp[SP_W-1:0] - 1'b1;
  assign reg_we    = (w_exec && w_wr_op) || (w_mem_done && w_pop);
  assign pc_inc    = (w_exec && (w_wr_op || w_nop || (w_jcc && !branch_taken))) || w_mem_done;
  assign pc_load   = w_exec && (w_jmp || (w_jcc && branch_taken));
  assign sp        = r_sp[SP_W-1:0];
  assign halted    = r_halted;
  assign fault     = r_fault;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_sp     <= '0;
      r_halted <= 1'b0;
      r_fault  <= 2'b00;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= imem_ready ? S_DECODE : S_FETCH;
        S_DECODE: r_state <= S_EXEC;
        S_EXEC: begin
          if (w_stop) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
            r_fault  <= w_ill ? 2'b11 : w_hlt ? 2'b00 : w_push ? 2'b01 : 2'b10;
          end else begin
            r_state <= (w_push || w_pop) ? S_MEM : S_FETCH;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            r_sp    <= w_push ? r_sp + 1'b1 : r_sp - 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end
`ifdef SEQ_RETIRE_COUNT_EN
  logic [31:0] r_retired;
  assign retired = r_retired;
  always_ff @(posedge clock) begin
    if (reset) r_retired <= '0;
    else if (pc_inc || pc_load) r_retired <= r_retired + 32'd1;
  end
`endif
endmodule

// File: doc/seq_ctrl.md
Name: seq_ctrl

Overview:
- Multi-cycle instruction sequencer for the J17 core.
- Steps each instruction through fetch, decode, execute and optional stack-memory access, then strobes the PC, instruction register, register file and data memory.
- Owns the hardware stack pointer used by PUSH/POP.
- Sits beside the combinational decoder, which supplies alucode/imControl/operand fields; seq_ctrl only decides *when* things happen.

Parameters:
- SP_W, 8, stack pointer width in bits.
- STACK_DEPTH, 256, number of stack entries; must be ≤ 2^SP_W.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_ready  in  1  instruction word valid this cycle.
- imem_req  out  1  instruction fetch request.
- ir_load  out  1  load instruction register.
- opcode  in  6  instruction[31:26] from the IR.
- branch_taken  in  1  condition result for the current Jcc; sampled in EXEC.
- dmem_ready  in  1  data access complete this cycle.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = write (PUSH), 0 = read (POP).
- dmem_addr  out  SP_W  stack slot address.
- pc_inc  out  1  PC <= PC+1.
- pc_load  out  1  PC <= jump target.
- reg_we  out  1  register file write enable.
- sp  out  SP_W  current stack pointer (number of occupied entries).
- halted  out  1  core stopped.
- fault  out  2  00 none, 01 stack overflow, 10 stack underflow, 11 illegal opcode.

Behaviour:
- Reset and clocking:
  - Reset is synchronous, active-high, sampled on the rising edge of clock.
  - Reset state: state=FETCH, sp=0, halted=0, fault=00.
  - All strobes (imem_req, ir_load, dmem_req, dmem_we, pc_inc, pc_load, reg_we) are forced 0 while reset=1.
  - Reset wins over every other event, including mid-MEM or HALT; an outstanding memory access is abandoned.
- Strobes are combinational from state and inputs; state, sp, halted and fault are registered.
- States: FETCH, DECODE, EXEC, MEM, HALT.
- FETCH:
  - imem_req=1.
  - If imem_ready: ir_load=1 the same cycle, next state DECODE.
  - Otherwise stay in FETCH with no other strobes.
- DECODE: one cycle, no strobes, next state EXEC. Opcode classes:
  - ALU 0–14.
  - JMP 15; Jcc 16–23.
  - MOV 24, NOP 25, HLT 26, PUSH 27, POP 28, MOVI 29.
  - Opcodes 30–63 are illegal.
- EXEC, per class:
  - ALU, MOV, MOVI: reg_we=1, pc_inc=1, next state FETCH.
  - NOP: pc_inc=1, next state FETCH.
  - JMP: pc_load=1, next state FETCH.
  - Jcc: pc_load=branch_taken and pc_inc=!branch_taken (exactly one is asserted), next state FETCH.
  - HLT: no strobes; halted<=1, next state HALT; PC is not advanced.
  - PUSH: if sp==STACK_DEPTH, then fault<=01, halted<=1, next state HALT. Otherwise next state MEM.
  - POP: if sp==0, then fault<=10, halted<=1, next state HALT. Otherwise next state MEM.
  - Illegal: fault<=11, halted<=1, next state HALT.
- MEM (PUSH/POP only):
  - dmem_req=1 every cycle until dmem_ready.
  - PUSH: dmem_we=1, dmem_addr=sp.
  - POP: dmem_we=0, dmem_addr=sp-1.
  - When dmem_ready=1:
    - PUSH: sp<=sp+1, pc_inc=1.
    - POP: sp<=sp-1, reg_we=1, pc_inc=1.
    - Next state FETCH.
  - dmem_addr and dmem_we stay stable while waiting for dmem_ready.
- HALT:
  - Absorbing state; all strobes 0.
  - halted=1 and fault hold until reset.
- Latency with zero-wait memories:
  - ALU/MOV/NOP/jump: 3 cycles.
  - PUSH/POP: 4 cycles.
  - Each memory wait cycle adds 1.
- Invariants:
  - Exactly one of pc_inc/pc_load per retired instruction.
  - sp never leaves 0..STACK_DEPTH.
  - sp changes only in MEM on dmem_ready.

Optional Feature:
- Macro SEQ_RETIRE_COUNT_EN.
- When defined:
  - Adds output retired [31:0].
  - Reset value 0.
  - Increments by 1 in every cycle where pc_inc or pc_load is asserted, with 32-bit wrap-around (0xFFFFFFFF -> 0).
  - HLT and faulting instructions are not counted.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- ADD (opcode 0), imem_ready and dmem_ready held 1 → ir_load at cycle 1, reg_we+pc_inc at cycle 3, imem_req again at cycle 4; sp stays 0.
- JE (16) with branch_taken=1, then JNE (19) with branch_taken=0 → first gives pc_load=1/pc_inc=0, second gives pc_inc=1/pc_load=0; never both high.
- PUSH ×3, then POP ×3, dmem_ready delayed 2 cycles each → dmem_addr 0,1,2 (we=1), then 2,1,0 (we=0); sp 1,2,3,2,1,0; reg_we only on the POP ready cycles.
- STACK_DEPTH=4: five PUSHes → fifth gives fault=01, halted=1, no dmem_req; a POP at sp=0 after reset → fault=10.
- Opcode 45 → fault=11, halted=1; HLT (26) → halted=1, fault=00, no pc_inc; in both cases strobes stay 0 for 10 cycles.
- Reset asserted mid-MEM with dmem_ready=0 and sp=2 → next cycle state FETCH, sp=0, fault=00, dmem_req=0; with SEQ_RETIRE_COUNT_EN, retired=0.
